priority_irq_encoder: RTL and testbench
=======================================

# priority_irq_encoder

Registered, parametrised priority encoder with sticky pending requests, per-line masking and an acknowledge handshake, generalising the combinational 4-to-2 priority encoder to N inputs. It captures request pulses into a pending register and presents the index of the highest-priority unmasked pending line. Priority direction is selected at elaboration. It clears a line only when the consumer acknowledges it. It sits between raw event/interrupt sources and a single sequential consumer (controller FSM or CPU interrupt logic).

## Interface
- N, default 8: number of request lines; legal range 2..64.
- IDXW, default 3: index width; must equal ceil(log2(N)).
- LOWEST_FIRST, default 0: 0 = highest index wins (bit N-1 highest priority); 1 = index 0 wins.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request lines; a 1 on bit i in any cycle sets pending[i].
- mask  in  N  1 on bit i blocks line i from selection; it does not block capture into pending.
- ack  in  1  consumer acknowledge; meaningful only while valid=1.
- y  out  IDXW  registered index of the selected line; 0 when valid=0.
- valid  out  1  registered; 1 when at least one unmasked pending line exists.
- pending  out  N  registered pending vector; masked bits are included.

## Operation
- Next-state pending value: pend_nxt = (pending & ~clr) | req.
  - clr is one-hot at bit y when ack=1 and valid=1; otherwise 0.
  - req overrides clr: if req[y] and ack occur in the same cycle, pending[y] stays 1.
- Selection: sel = pend_nxt & ~mask, using mask of the current cycle.
- At each edge: pending <= pend_nxt; valid <= |sel; y <= priority index of sel, or 0 if sel = 0.
- Priority:
  - LOWEST_FIRST=0: highest set bit of sel.
  - LOWEST_FIRST=1: lowest set bit of sel.
- ack with valid=0 is ignored; no state change from ack.
- Only one line is cleared per ack. Other pending lines remain, and the next one is presented on the following cycle.
- Masking a pending line:
  - The line is held in pending and does not drive valid.
  - Unmasking makes it eligible at the next edge.
- Width rules: y is zero-extended within IDXW. Indices at or above N never occur.

## Timing
- Reset: while rst=1 at an edge, pending=0, y=0, valid=0. req, mask and ack are ignored in that cycle.
- Reset mid-operation discards all pending requests. No request captured before or during reset survives.
- Latency: req[i] high in cycle k gives pending[i]=1 and (if unmasked and highest priority) y=i, valid=1 after edge k+1. This is one cycle.
- ack in cycle k (valid=1):
  - pending[y] is cleared at edge k+1.
  - y/valid at edge k+1 already reflect the remaining lines, so back-to-back acks never hit the same line twice.
- Continuous ack with N lines pending drains them in priority order, one per cycle. valid falls the cycle after the last ack, unless a new req arrives.
- A new higher-priority req arriving while a lower line is presented pre-empts it at the next edge. The lower line stays pending.
- A mask change takes effect at the next edge (same one-cycle latency as req).

## Test plan
- Reset/idle (N=8, LOWEST_FIRST=0): assert rst 2 cycles with req=8'hFF → pending=0, y=0, valid=0 after release; req=0 → valid stays 0.
- Single and priority: req=8'b0000_0100 for one cycle → y=2, valid=1 next cycle and held. Then pulse req=8'b1000_0000 → y=7 next cycle, pending=8'b1000_0100.
- Drain with ack: pending=8'b1010_0001, ack held high → y sequence 7, 5, 0 on consecutive cycles, then valid=0, pending=0.
- Masking: pending=8'b1000_0010, mask=8'b1000_0000 → y=1, valid=1. Then mask=0 → y=7 next cycle. Then mask=8'hFF → valid=0, pending unchanged.
- Simultaneous ack and req on the same line: y=3, ack=1 and req=8'b0000_1000 in the same cycle → pending[3] remains 1, y=3, valid=1.
- LOWEST_FIRST=1, N=16, IDXW=4: req=16'h8011 → y=0; after ack y=4; after ack y=15. Also assert rst mid-drain → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/priority_irq_encoder_if.sv
// Request/acknowledge bus between interrupt sources, the priority encoder
// and its single sequential consumer.
interface priority_irq_encoder_if #(
  parameter int N    = 8,
  parameter int IDXW = 3
);
  logic [N-1:0]    req;
  logic [N-1:0]    mask;
  logic            ack;
  logic [IDXW-1:0] y;
  logic            valid;
  logic [N-1:0]    pending;

  // Sources and consumer side
  modport master (
    output req,
    output mask,
    output ack,
    input  y,
    input  valid,
    input  pending
  );

  // Encoder side
  modport slave (
    input  req,
    input  mask,
    input  ack,
    output y,
    output valid,
    output pending
  );
endinterface

// File: rtl/priority_irq_encoder.sv
// Registered N-input priority encoder with sticky pending requests,
// per-line masking and a one-line-per-ack clear handshake.
module priority_irq_encoder #(
  parameter int N            = 8,
  parameter int IDXW         = 3,
  parameter int LOWEST_FIRST = 0
) (
  input logic                  clk,
  input logic                  rst,
  priority_irq_encoder_if.slave bus
);

  logic [N-1:0]    pending_r;
  logic [IDXW-1:0] y_r;
  logic            valid_r;

  logic [N-1:0]    clr_s;
  logic [N-1:0]    pend_nxt_s;
  logic [N-1:0]    sel_s;
  logic [IDXW-1:0] idx_s;

  // Clear only the presented line, and only when an ack meets a valid output
  always_comb begin
    clr_s = '0;
    if (bus.ack && valid_r) begin
      clr_s[y_r] = 1'b1;
    end else begin
      clr_s = '0;
    end
  end

  // New requests win over a same-cycle clear; masking only affects selection
  always_comb begin
    pend_nxt_s = (pending_r & ~clr_s) | bus.req;
    sel_s      = pend_nxt_s & ~bus.mask;
  end

  // Priority search over the eligible lines; the last match in scan order wins
  always_comb begin
    idx_s = '0;
    if (LOWEST_FIRST != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (sel_s[i]) begin
          idx_s = IDXW'(i);
        end else begin
          idx_s = idx_s;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sel_s[i]) begin
          idx_s = IDXW'(i);
        end else begin
          idx_s = idx_s;
        end
      end
    end
  end

  // State and output registers; reset discards everything captured so far
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
      y_r       <= '0;
      valid_r   <= 1'b0;
    end else begin
      pending_r <= pend_nxt_s;
      y_r       <= idx_s;
      valid_r   <= |sel_s;
    end
  end

  assign bus.pending = pending_r;
  assign bus.y       = y_r;
  assign bus.valid   = valid_r;

endmodule

// File: tb/tb_priority_irq_encoder.sv
// Self-checking bench: directed vector table for N=8 highest-first,
// hand sequence for N=16 lowest-first, then random traffic on both
// instances against an arithmetic reference model.
module tb_priority_irq_encoder;

  logic clk;
  logic rst8;
  logic rst16;

  priority_irq_encoder_if #(.N(8),  .IDXW(3)) if8 ();
  priority_irq_encoder_if #(.N(16), .IDXW(4)) if16 ();

  priority_irq_encoder #(.N(8), .IDXW(3), .LOWEST_FIRST(0)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (if8)
  );

  priority_irq_encoder #(.N(16), .IDXW(4), .LOWEST_FIRST(1)) dut16 (
    .clk (clk),
    .rst (rst16),
    .bus (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint unsigned m8_pend  = 64'd0;
  int              m8_y     = 0;
  bit              m8_v     = 1'b0;
  longint unsigned m16_pend = 64'd0;
  int              m16_y    = 0;
  bit              m16_v    = 1'b0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] exp_y;
    logic       exp_v;
    logic [7:0] exp_pend;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: clear presented line on a valid ack, OR in requests,
  // then pick highest or lowest eligible index by repeated halving.
  task automatic model_step(input int n, input bit lowest, input bit r,
                            input longint unsigned rq, input longint unsigned mk,
                            input bit ak, inout longint unsigned pend,
                            inout int yy, inout bit vv);
    longint unsigned elig;
    if (r) begin
      pend = 64'd0;
      yy   = 0;
      vv   = 1'b0;
    end else begin
      if (ak && vv && ((pend >> yy) % 64'd2 == 64'd1))
        pend = pend - (64'd1 << yy);
      pend = pend | rq;
      elig = pend & ~mk & ((64'd1 << n) - 64'd1);
      yy = 0;
      if (elig == 64'd0) begin
        vv = 1'b0;
      end else begin
        vv = 1'b1;
        if (lowest) begin
          while (elig % 64'd2 == 64'd0) begin
            elig = elig / 64'd2;
            yy++;
          end
        end else begin
          while (elig > 64'd1) begin
            elig = elig / 64'd2;
            yy++;
          end
        end
      end
    end
  endtask

  // Advance both models with the inputs currently applied, then let the DUTs
  // take the same edge and settle.
  task automatic tick();
    model_step(8, 1'b0, rst8, 64'(if8.req), 64'(if8.mask), if8.ack, m8_pend, m8_y, m8_v);
    model_step(16, 1'b1, rst16, 64'(if16.req), 64'(if16.mask), if16.ack, m16_pend, m16_y, m16_v);
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string name, input logic [3:0] ey, input logic ev, input logic [15:0] ep);
    chk({name, ".y"}, 64'(if16.y), 64'(ey));
    chk({name, ".valid"}, 64'(if16.valid), 64'(ev));
    chk({name, ".pending"}, 64'(if16.pending), 64'(ep));
  endtask

  initial begin
    rst8      = 1'b1;
    rst16     = 1'b1;
    if8.req   = 8'h00;
    if8.mask  = 8'h00;
    if8.ack   = 1'b0;
    if16.req  = 16'h0000;
    if16.mask = 16'h0000;
    if16.ack  = 1'b0;

    // rst req mask ack | y v pending
    vq.push_back('{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00}); // reset ignores req
    vq.push_back('{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00});
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00}); // idle
    vq.push_back('{1'b0, 8'h04, 8'h00, 1'b0, 3'd2, 1'b1, 8'h04}); // single
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 3'd2, 1'b1, 8'h04}); // held
    vq.push_back('{1'b0, 8'h80, 8'h00, 1'b0, 3'd7, 1'b1, 8'h84}); // higher wins
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 3'd7, 1'b1, 8'h84});
    vq.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00}); // mid-run reset
    vq.push_back('{1'b0, 8'hA1, 8'h00, 1'b0, 3'd7, 1'b1, 8'hA1}); // drain setup
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 3'd5, 1'b1, 8'h21});
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b1, 8'h01});
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00});
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00}); // ack while idle
    vq.push_back('{1'b0, 8'h82, 8'h80, 1'b0, 3'd1, 1'b1, 8'h82}); // masked top
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 3'd7, 1'b1, 8'h82}); // unmask
    vq.push_back('{1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h82}); // all masked
    vq.push_back('{1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h82}); // ack ignored
    vq.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00});
    vq.push_back('{1'b0, 8'h08, 8'h00, 1'b0, 3'd3, 1'b1, 8'h08});
    vq.push_back('{1'b0, 8'h08, 8'h00, 1'b1, 3'd3, 1'b1, 8'h08}); // req beats ack
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00});
    vq.push_back('{1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b1, 8'h01});
    vq.push_back('{1'b0, 8'h40, 8'h00, 1'b0, 3'd6, 1'b1, 8'h41}); // pre-empt
    vq.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b1, 8'h01});
    vq.push_back('{1'b0, 8'h10, 8'h01, 1'b0, 3'd4, 1'b1, 8'h11});

    foreach (vq[i]) begin
      rst8     = vq[i].rst;
      if8.req  = vq[i].req;
      if8.mask = vq[i].mask;
      if8.ack  = vq[i].ack;
      tick();
      chk($sformatf("vec%0d.y", i), 64'(if8.y), 64'(vq[i].exp_y));
      chk($sformatf("vec%0d.valid", i), 64'(if8.valid), 64'(vq[i].exp_v));
      chk($sformatf("vec%0d.pending", i), 64'(if8.pending), 64'(vq[i].exp_pend));
    end

    // Lowest-first instance: drain 16'h8011 and reset in the middle
    rst8 = 1'b1;
    if8.req = 8'h00; if8.mask = 8'h00; if8.ack = 1'b0;
    rst16 = 1'b0;
    if16.req = 16'h8011;
    tick();
    chk16("lf_first", 4'd0, 1'b1, 16'h8011);
    if16.req = 16'h0000;
    if16.ack = 1'b1;
    tick();
    chk16("lf_ack1", 4'd4, 1'b1, 16'h8010);
    tick();
    chk16("lf_ack2", 4'd15, 1'b1, 16'h8000);
    rst16 = 1'b1;
    tick();
    chk16("lf_rst", 4'd0, 1'b0, 16'h0000);
    rst16 = 1'b0;
    if16.ack = 1'b0;
    if16.req = 16'h0006;
    tick();
    chk16("lf_after_rst", 4'd1, 1'b1, 16'h0006);
    if16.req = 16'h0000;
    if16.mask = 16'h0002;
    tick();
    chk16("lf_mask", 4'd2, 1'b1, 16'h0006);

    // Random traffic on both instances against the reference model
    rst8 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst8      = ($urandom_range(0, 39) == 0);
      rst16     = ($urandom_range(0, 39) == 0);
      if8.req   = 8'($urandom & $urandom & $urandom);
      if8.mask  = 8'($urandom & $urandom);
      if8.ack   = 1'($urandom_range(0, 1));
      if16.req  = 16'($urandom & $urandom & $urandom);
      if16.mask = 16'($urandom & $urandom);
      if16.ack  = 1'($urandom_range(0, 1));
      tick();
      chk("rnd8.y", 64'(if8.y), 64'(m8_y));
      chk("rnd8.valid", 64'(if8.valid), 64'(m8_v));
      chk("rnd8.pending", 64'(if8.pending), m8_pend);
      chk("rnd16.y", 64'(if16.y), 64'(m16_y));
      chk("rnd16.valid", 64'(if16.valid), 64'(m16_v));
      chk("rnd16.pending", 64'(if16.pending), m16_pend);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
